// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: state codes, owner codes and the DMA word mode shared by the arbiter files
package bus_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CPU  = 2'd1,
    ARB_DMA  = 2'd2
  } arb_state_e;
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_DMA  = 2'd2;
  localparam logic [2:0] DM_WORD  = 3'b010;
endpackage

// File: rtl/bus_arbiter_timer.sv
// arb_timer: bus_ack wait counter, only built when ARB_TIMEOUT_EN is defined
`ifdef ARB_TIMEOUT_EN
module arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  logic [15:0] cnt_q;
  // count ack-less transfer cycles; cleared on every grant
  always_ff @(posedge clk) begin
    if (rst || clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + 16'd1;
  end
  // expiry lands on the TIMEOUT-th ack-less cycle so that cycle's edge terminates the transfer
  assign expired_o = en_i & (cnt_q == 16'(TIMEOUT - 1));
endmodule
`endif

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the device bus between CPU and DMA; ARB_TIMEOUT_EN adds ack timeout with bus_err
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_mode,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_stop,
  output logic [31:0] cpu_rdata,
  output logic        cpu_valid,
  input  logic        dma_req,
  input  logic [31:0] dma_addr,
  input  logic        dma_we,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_ack,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [2:0]  bus_mode,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err,
  output logic [1:0]  owner
);
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
    $error("bus_arbiter: parameter out of range");
  end
  arb_state_e  state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [1:0]  owner_q, owner_d;
  logic        bus_req_q, bus_we_q, cpu_valid_q, dma_ack_q;
  logic [31:0] bus_addr_q, bus_wdata_q, cpu_rdata_q, dma_rdata_q, rd_d;
  logic [2:0]  bus_mode_q;
  logic        xfer, cpu_pend, cpu_gnt, dma_gnt, done, expired;
  assign xfer     = state_q != ARB_IDLE;
  assign cpu_pend = cpu_req & ~cpu_stop;
  // a pending CPU request keeps priority even in its own completion cycle, where it is only barred from re-grant
  assign dma_gnt  = ~xfer & dma_req & (~cpu_pend | (starve_q == 4'(STARVE_LIMIT)));
  assign cpu_gnt  = ~xfer & cpu_pend & ~cpu_valid_q & ~dma_gnt;
  assign done     = xfer & (bus_ack | expired);
`ifdef ARB_TIMEOUT_EN
  logic bus_err_q;
  arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (cpu_gnt | dma_gnt),
    .en_i      (xfer & ~bus_ack),
    .expired_o (expired)
  );
  assign bus_err = bus_err_q;
`else
  assign expired = 1'b0;
  assign bus_err = 1'b0;
`endif
  // next state, owner, starvation count and returned read data
  always_comb begin
    state_d  = cpu_gnt ? ARB_CPU : dma_gnt ? ARB_DMA : done ? ARB_IDLE : state_q;
    owner_d  = cpu_gnt ? OWN_CPU : dma_gnt ? OWN_DMA : done ? OWN_NONE : owner_q;
    starve_d = (~dma_req | dma_gnt) ? 4'd0 : cpu_gnt ? starve_q + 4'd1 : starve_q;
    rd_d     = (bus_we_q | ~bus_ack) ? 32'h0 : bus_rdata;
  end
  // arbiter FSM with registered bus and completion outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_NONE;
      starve_q    <= '0;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_we_q    <= 1'b0;
      bus_mode_q  <= '0;
      bus_wdata_q <= '0;
      cpu_valid_q <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
`ifdef ARB_TIMEOUT_EN
      bus_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      cpu_valid_q <= done & (state_q == ARB_CPU);
      dma_ack_q   <= done & (state_q == ARB_DMA);
`ifdef ARB_TIMEOUT_EN
      bus_err_q   <= done & expired;
`endif
      if (cpu_gnt || dma_gnt) begin
        bus_req_q   <= 1'b1;
        bus_addr_q  <= cpu_gnt ? cpu_addr : dma_addr;
        bus_we_q    <= cpu_gnt ? cpu_we : dma_we;
        bus_mode_q  <= cpu_gnt ? cpu_mode : DM_WORD;
        bus_wdata_q <= cpu_gnt ? cpu_wdata : dma_wdata;
      end else if (done) bus_req_q <= 1'b0;
      if (done && state_q == ARB_CPU) cpu_rdata_q <= rd_d;
      if (done && state_q == ARB_DMA) dma_rdata_q <= rd_d;
    end
  end
  assign bus_req   = bus_req_q;
  assign bus_addr  = bus_addr_q;
  assign bus_we    = bus_we_q;
  assign bus_mode  = bus_mode_q;
  assign bus_wdata = bus_wdata_q;
  assign cpu_valid = cpu_valid_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_ack   = dma_ack_q;
  assign dma_rdata = dma_rdata_q;
  assign owner     = owner_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scoreboard bench for bus_arbiter
module tb_bus_arbiter;
  logic clk = 0, rst = 1;
  logic cpu_req = 0, cpu_we = 0, cpu_stop = 0, cpu_valid;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, cpu_rdata;
  logic [2:0] cpu_mode = 0, bus_mode;
  logic dma_req = 0, dma_we = 0, dma_ack;
  logic [31:0] dma_addr = 0, dma_wdata = 0, dma_rdata;
  logic bus_req, bus_we, bus_ack = 0, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata = 0;
  logic [1:0] owner;
  always #5 clk = ~clk;
  bus_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_mode(cpu_mode),
    .cpu_wdata(cpu_wdata), .cpu_stop(cpu_stop), .cpu_rdata(cpu_rdata), .cpu_valid(cpu_valid),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_we(dma_we), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_we(bus_we), .bus_mode(bus_mode),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err),
    .owner(owner)
  );
  typedef struct {logic [1:0] own; logic [31:0] rd; logic err;} exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0, cpu_pulses = 0, dma_pulses = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (cpu_valid) cpu_pulses++;
    if (dma_ack) dma_pulses++;
    if (cpu_valid || dma_ack) begin
      if (sb.size() == 0) chk("sb_nonempty", 32'(sb.size()), 32'd1);
      else begin
        e = sb.pop_front();
        chk("done_who", {30'b0, cpu_valid, dma_ack}, (e.own == 2'd1) ? 32'd2 : 32'd1);
        chk("done_rdata", (e.own == 2'd1) ? cpu_rdata : dma_rdata, e.rd);
        chk("done_err", {31'b0, bus_err}, {31'b0, e.err});
      end
    end
  endtask
  task automatic wait_req(input string tag);
    int n = 0;
    while (!bus_req && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, {31'b0, bus_req}, 32'd1);
  endtask
  task automatic ack(input logic [1:0] own, input logic [31:0] rd, input logic we);
    sb.push_back('{own, we ? 32'h0 : rd, 1'b0});
    bus_ack = 1;
    bus_rdata = rd;
    tick();
    bus_ack = 0;
    bus_rdata = 32'hDEAD_BEEF;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int p, q;
    bit d;
    tick();
    tick();
    chk("rst_bus_req", {31'b0, bus_req}, 0);
    chk("rst_owner", {30'b0, owner}, 0);
    chk("rst_done", {30'b0, cpu_valid, dma_ack}, 0);
    chk("rst_err", {31'b0, bus_err}, 0);
    rst = 0;
    tick();
    cpu_req = 1; cpu_addr = 32'h7F00; cpu_we = 0; cpu_mode = 3'b100;
    tick();
    chk("t1_req", {31'b0, bus_req}, 1);
    chk("t1_owner", {30'b0, owner}, 1);
    chk("t1_addr", bus_addr, 32'h7F00);
    chk("t1_mode", {29'b0, bus_mode}, 32'b100);
    chk("t1_we", {31'b0, bus_we}, 0);
    p = cpu_pulses;
    ack(2'd1, 32'h1234, 1'b0);
    chk("t1_valid", {31'b0, cpu_valid}, 1);
    chk("t1_req_drop", {31'b0, bus_req}, 0);
    chk("t1_owner_idle", {30'b0, owner}, 0);
    tick();
    chk("t1_no_regrant", {31'b0, bus_req}, 0);
    chk("t1_pulse_once", 32'(cpu_pulses - p), 1);
    cpu_req = 0;
    tick();
    cpu_req = 1; cpu_addr = 32'h4000; cpu_mode = 3'b001;
    dma_req = 1; dma_addr = 32'hD000; dma_we = 1; dma_wdata = 32'hCAFE_0001;
    p = cpu_pulses; q = dma_pulses;
    for (int i = 0; i < 10; i++) begin
      d = (i % 5 == 4);
      wait_req("t2");
      chk("t2_owner", {30'b0, owner}, d ? 32'd2 : 32'd1);
      chk("t2_addr", bus_addr, d ? 32'hD000 : 32'h4000);
      chk("t2_mode", {29'b0, bus_mode}, d ? 32'b010 : 32'b001);
      if (d) chk("t2_wdata", bus_wdata, 32'hCAFE_0001);
      ack(d ? 2'd2 : 2'd1, 32'h1000 + i, d);
      if (i == 9) begin
        cpu_req = 0;
        dma_req = 0;
      end
    end
    tick();
    chk("t2_idle", {31'b0, bus_req}, 0);
    chk("t2_cpu_count", 32'(cpu_pulses - p), 8);
    chk("t2_dma_count", 32'(dma_pulses - q), 2);
    dma_we = 0;
    cpu_req = 1; cpu_stop = 1; cpu_addr = 32'h2000; cpu_mode = 3'b010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_stop_no_req", {31'b0, bus_req}, 0);
    end
    cpu_stop = 0;
    tick();
    chk("t3_grant", {30'b0, owner}, 1);
    cpu_stop = 1;
    p = cpu_pulses;
    tick();
    tick();
    chk("t3_hold", {31'b0, bus_req}, 1);
    ack(2'd1, 32'h55AA, 1'b0);
    cpu_req = 0; cpu_stop = 0;
    tick();
    chk("t3_pulse_once", 32'(cpu_pulses - p), 1);
    p = cpu_pulses; q = dma_pulses;
    bus_ack = 1;
    tick();
    tick();
    bus_ack = 0;
    chk("t3_idle_ack", 32'(cpu_pulses - p + dma_pulses - q), 0);
    chk("t3_idle_req", {31'b0, bus_req}, 0);
    dma_req = 1; dma_addr = 32'hD0D0;
    tick();
    chk("t4_owner", {30'b0, owner}, 2);
    chk("t4_addr", bus_addr, 32'hD0D0);
    tick();
    dma_addr = 32'hE0E0;
    rst = 1;
    tick();
    chk("t4_rst_req", {31'b0, bus_req}, 0);
    chk("t4_rst_owner", {30'b0, owner}, 0);
    chk("t4_rst_ack", {31'b0, dma_ack}, 0);
    chk("t4_rst_addr", bus_addr, 0);
    rst = 0;
    tick();
    chk("t4_regrant", {30'b0, owner}, 2);
    chk("t4_reload", bus_addr, 32'hE0E0);
    ack(2'd2, 32'hBEEF, 1'b0);
    dma_req = 0;
    tick();
    cpu_req = 1; cpu_addr = 32'h5000; cpu_we = 0;
    tick();
    cpu_req = 0;
    chk("t5_grant", {30'b0, owner}, 1);
    p = cpu_pulses;
`ifdef ARB_TIMEOUT_EN
    sb.push_back('{2'd1, 32'h0, 1'b1});
    bus_rdata = 32'h7777;
    for (int i = 0; i < 7; i++) tick();
    chk("t5_wait", 32'(cpu_pulses - p), 0);
    tick();
    chk("t5_valid", {31'b0, cpu_valid}, 1);
    chk("t5_err", {31'b0, bus_err}, 1);
    chk("t5_rdata", cpu_rdata, 0);
    tick();
    chk("t5_idle", {30'b0, owner}, 0);
    chk("t5_err_pulse", {31'b0, bus_err}, 0);
`else
    for (int i = 0; i < 20; i++) tick();
    chk("t5_hold_req", {31'b0, bus_req}, 1);
    chk("t5_no_err", {31'b0, bus_err}, 0);
    chk("t5_no_valid", 32'(cpu_pulses - p), 0);
    rst = 1;
    tick();
    rst = 0;
`endif
    tick();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
